// File: rtl/demux_pkg.sv
// Shared types and helpers for the serial-in, parallel-out demultiplexer.
// The PARITY state is only reachable when DEMUX_PARITY_EN is defined.
package demux_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PARITY  = 2'd1,
        HOLD    = 2'd2
    } demux_state_e;

    // Widest word even_par can fold; callers zero-extend into it.
    localparam int PAR_MAX_W = 256;

    // Returns 1 when v holds an odd number of ones.
    function automatic logic even_par(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/demux_idx_counter.sv
// Lane index counter for demux_sipo: increments per accepted bit, wraps at m-1,
// and clears synchronously on flush or HOLD exit (DEMUX_PARITY_EN agnostic).
module demux_idx_counter
    import demux_pkg::*;
#(
    parameter int n = 3,
    parameter int m = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [n-1:0] idx
);

    localparam logic [n-1:0] LAST = n'(m - 1);

    // Clear wins over increment so a flush drops the coincident bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/demux_sipo.sv
// Serial-in, parallel-out demux: bit k of a frame lands in out_data[k] (lane 0 first).
// DEMUX_PARITY_EN adds a trailing even-parity bit, the PARITY state and parity_err.
module demux_sipo
    import demux_pkg::*;
#(
    parameter int n = 3,
    parameter int m = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         flush,
    output logic [n-1:0] sel,
    output logic [m-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
`ifdef DEMUX_PARITY_EN
    ,
    output logic         parity_err
`endif
);

    localparam logic [n-1:0] LAST = n'(m - 1);

    demux_state_e state;
    logic [m-1:0] shadow;
    logic [m-1:0] shadow_nxt;
    logic         accept;
    logic         in_frame;
    logic         cnt_inc;
    logic         cnt_clr;
    logic         hold_exit;

    assign din_ready = (state != HOLD);
    assign accept    = din_valid && din_ready;
    assign in_frame  = (state != HOLD);
    assign hold_exit = (state == HOLD) && out_ready;
    assign cnt_inc   = accept && !flush && (state == COLLECT);
    assign cnt_clr   = (flush && in_frame) || hold_exit;

    // Shadow with the incoming bit merged into lane sel; the final lane goes
    // straight to out_data from here so no extra cycle is spent.
    for (genvar i = 0; i < m; i++) begin : g_lane
        assign shadow_nxt[i] = (sel == n'(i)) ? din : shadow[i];
    end

    demux_idx_counter #(.n(n), .m(m)) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .idx   (sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            shadow    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef DEMUX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (flush) begin
                        shadow <= '0;
                    end else if (accept) begin
                        shadow <= shadow_nxt;
                        if (sel == LAST) begin
`ifdef DEMUX_PARITY_EN
                            state <= PARITY;
`else
                            out_data  <= shadow_nxt;
                            out_valid <= 1'b1;
                            state     <= HOLD;
`endif
                        end
                    end
                end
`ifdef DEMUX_PARITY_EN
                PARITY: begin
                    if (flush) begin
                        shadow <= '0;
                        state  <= COLLECT;
                    end else if (accept) begin
                        parity_err <= even_par(PAR_MAX_W'(shadow)) ^ din;
                        out_data   <= shadow;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
`endif
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        shadow    <= '0;
                        state     <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_sipo.sv
// Directed bench for demux_sipo with a word scoreboard; DEMUX_PARITY_EN adds parity steps.
module tb_demux_sipo;

    localparam int N = 3;
    localparam int M = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         din = 1'b0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         flush = 1'b0;
    logic [N-1:0] sel;
    logic [M-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
`ifdef DEMUX_PARITY_EN
    logic         parity_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [M-1:0] exp_q[$];

    demux_sipo #(.n(N), .m(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .flush     (flush),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, then land 1 time unit after the edge.
    task automatic cyc(input logic v, input logic d, input logic fl, input logic rdy);
        din_valid = v;
        din       = d;
        flush     = fl;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Send a full frame LSB first, checking sel before each accept; optional
    // idle gap cycles between bits. With parity, a correct parity bit follows.
    task automatic send_frame(input logic [M-1:0] w, input logic rdy, input logic gaps);
        exp_q.push_back(w);
        for (int i = 0; i < M; i++) begin
            chk($sformatf("sel_step%0d", i), 32'(sel), 32'(i));
            cyc(1'b1, w[i], 1'b0, rdy);
            if (gaps && i != M - 1) begin
                cyc(1'b0, ~w[i], 1'b0, rdy);
                chk($sformatf("sel_gap%0d", i), 32'(sel), 32'((i + 1) % M));
            end
        end
`ifdef DEMUX_PARITY_EN
        chk("par_wait_valid", 32'(out_valid), 32'd0);
        cyc(1'b1, ^w, 1'b0, rdy);
`endif
    endtask

    // Scoreboard: a word transfers on the edge following a negedge with valid&&ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(out_data), 32'hDEAD);
            end else begin
                chk("sb_word", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // Reset state, including din_ready while reset is held.
        #12;
        chk("rst_din_ready", 32'(din_ready), 32'd1);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame 1,0,0,1,0,1,1,1 -> 0xE9.
        send_frame(8'hE9, 1'b1, 1'b0);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_ready_low", 32'(din_ready), 32'd0);
        chk("basic_sel_wrap", 32'(sel), 32'd0);
        chk("basic_data", 32'(out_data), 32'hE9);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_valid_drop", 32'(out_valid), 32'd0);
        chk("basic_ready_back", 32'(din_ready), 32'd1);

        // Backpressure: hold for 5 cycles while offering bits that must be ignored.
        send_frame(8'hE9, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, k[0], 1'b0, 1'b0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'hE9);
            chk("bp_ready_low", 32'(din_ready), 32'd0);
            chk("bp_sel", 32'(sel), 32'd0);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("bp_valid_drop", 32'(out_valid), 32'd0);
        chk("bp_sel_after", 32'(sel), 32'd0);

        // Flush with a simultaneous valid bit: bit dropped, sel back to 0.
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("flush_pre_sel", 32'(sel), 32'd3);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("flush_sel", 32'(sel), 32'd0);
        chk("flush_no_valid", 32'(out_valid), 32'd0);
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("flush_data", 32'(out_data), 32'hA5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Gaps between every bit.
        send_frame(8'h3C, 1'b1, 1'b1);
        chk("gap_data", 32'(out_data), 32'h3C);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("mid_sel", 32'(sel), 32'd4);
        din_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(din_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            chk("arst_no_pulse", 32'(out_valid), 32'd0);
        end
        send_frame(8'h5A, 1'b1, 1'b0);
        chk("post_rst_data", 32'(out_data), 32'h5A);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef DEMUX_PARITY_EN
        // Correct parity (0xE9 has five ones -> parity bit 1).
        send_frame(8'hE9, 1'b1, 1'b0);
        chk("par_ok_err", 32'(parity_err), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        // Wrong parity bit: word still delivered, error flagged.
        exp_q.push_back(8'hE9);
        for (int i = 0; i < M; i++) cyc(1'b1, 8'hE9 >> i, 1'b0, 1'b1);
        chk("par_bad_pending", 32'(out_valid), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("par_bad_err", 32'(parity_err), 32'd1);
        chk("par_bad_data", 32'(out_data), 32'hE9);
        chk("par_bad_valid", 32'(out_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
